// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and the fetch/datapath.
// The controller owns every control output; the datapath drives inst and ZF.
interface mc_ctrl_if #(
    parameter int ALUOP_W = 4,
    parameter int REG_AW  = 5
);
    logic [31:0]        inst;
    logic               ZF;
    logic               IR_Write;
    logic               PC_Write;
    logic               PC0_Write;
    logic [1:0]         PC_s;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [REG_AW-1:0]  rd;
    logic               Reg_Write;
    logic [1:0]         w_data_s;
    logic               rs2_imm_s;
    logic [ALUOP_W-1:0] ALU_OP;
    logic               Mem_Write;
    logic [31:0]        imm32;
    logic               illegal;

    // Controller side
    modport master (
        input  inst, ZF,
        output IR_Write, PC_Write, PC0_Write, PC_s, rs1, rs2, rd, Reg_Write,
               w_data_s, rs2_imm_s, ALU_OP, Mem_Write, imm32, illegal
    );

    // Datapath / fetch side
    modport slave (
        output inst, ZF,
        input  IR_Write, PC_Write, PC0_Write, PC_s, rs1, rs2, rd, Reg_Write,
               w_data_s, rs2_imm_s, ALU_OP, Mem_Write, imm32, illegal
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control unit (R/I-ALU, LUI, LW, SW, BEQ, JAL).
// One instruction in flight; outputs are decoded from state and the fields
// latched in the decode state, except PC_Write in the branch state.
module mc_ctrl #(
    parameter int ALUOP_W = 4,
    parameter int REG_AW  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    mc_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EX  = 4'd2,
        S_WB  = 4'd3,
        S_MA  = 4'd4,
        S_LD  = 4'd5,
        S_LUI = 4'd6,
        S_BR  = 4'd7,
        S_JAL = 4'd8,
        S_ILL = 4'd9
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    state_t      state_q, state_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        f7b5_q, f7b5_d;
    logic [6:0]  opc_q, opc_d;
    logic [31:0] imm32_q, imm32_d;
    logic        illegal_q, illegal_d;

    logic        is_itype;
    logic [3:0]  alu_fn;

    // State and decoded-field registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            funct3_q  <= '0;
            f7b5_q    <= 1'b0;
            opc_q     <= '0;
            imm32_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            f7b5_q    <= f7b5_d;
            opc_q     <= opc_d;
            imm32_q   <= imm32_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state; fields and immediate are captured only while in decode
    always_comb begin
        state_d  = state_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        f7b5_d   = f7b5_q;
        opc_d    = opc_q;
        imm32_d  = imm32_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                rs1_d    = bus.inst[19:15];
                rs2_d    = bus.inst[24:20];
                rd_d     = bus.inst[11:7];
                funct3_d = bus.inst[14:12];
                f7b5_d   = bus.inst[30];
                opc_d    = bus.inst[6:0];
                state_d  = S_ILL;
                case (bus.inst[6:0])
                    OP_R: state_d = S_EX;
                    OP_IMM: begin
                        imm32_d = {{20{bus.inst[31]}}, bus.inst[31:20]};
                        state_d = S_EX;
                    end
                    OP_LOAD: begin
                        imm32_d = {{20{bus.inst[31]}}, bus.inst[31:20]};
                        if (bus.inst[14:12] == 3'b010) state_d = S_MA;
                    end
                    OP_STORE: begin
                        imm32_d = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
                        if (bus.inst[14:12] == 3'b010) state_d = S_MA;
                    end
                    OP_LUI: begin
                        imm32_d = {bus.inst[31:12], 12'b0};
                        state_d = S_LUI;
                    end
                    OP_BRANCH: begin
                        imm32_d = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                                   bus.inst[30:25], bus.inst[11:8], 1'b0};
                        if (bus.inst[14:12] == 3'b000) state_d = S_BR;
                    end
                    OP_JAL: begin
                        imm32_d = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                                   bus.inst[20], bus.inst[30:21], 1'b0};
                        state_d = S_JAL;
                    end
                    default: state_d = S_ILL;
                endcase
            end
            S_EX:  state_d = S_WB;
            S_WB:  state_d = S_IF;
            S_MA:  state_d = (opc_q == OP_LOAD) ? S_LD : S_IF;
            S_LD:  state_d = S_IF;
            S_LUI: state_d = S_IF;
            S_BR:  state_d = S_IF;
            S_JAL: state_d = S_IF;
            S_ILL: state_d = S_ILL;
            default: state_d = S_IF;
        endcase
        illegal_d = illegal_q | (state_d == S_ILL);
    end

    // ALU function from funct3/funct7[5]; bit30 of an I-type only matters for srai
    always_comb begin
        is_itype = (opc_q == OP_IMM);
        alu_fn   = ALU_ADD;
        case (funct3_q)
            3'b000: alu_fn = (!is_itype && f7b5_q) ? ALU_SUB : ALU_ADD;
            3'b001: alu_fn = ALU_SLL;
            3'b010: alu_fn = ALU_SLT;
            3'b011: alu_fn = ALU_SLTU;
            3'b100: alu_fn = ALU_XOR;
            3'b101: alu_fn = f7b5_q ? ALU_SRA : ALU_SRL;
            3'b110: alu_fn = ALU_OR;
            3'b111: alu_fn = ALU_AND;
            default: alu_fn = ALU_ADD;
        endcase
    end

    // Moore control outputs; write enables are suppressed while reset is asserted
    always_comb begin
        bus.IR_Write  = 1'b0;
        bus.PC_Write  = 1'b0;
        bus.PC0_Write = 1'b0;
        bus.PC_s      = 2'b10;
        bus.Reg_Write = 1'b0;
        bus.w_data_s  = 2'b00;
        bus.rs2_imm_s = 1'b0;
        bus.ALU_OP    = ALUOP_W'(ALU_ADD);
        bus.Mem_Write = 1'b0;
        case (state_q)
            S_IF: begin
                bus.IR_Write  = 1'b1;
                bus.PC_Write  = 1'b1;
                bus.PC0_Write = 1'b1;
                bus.PC_s      = 2'b00;
            end
            S_EX: begin
                bus.ALU_OP    = ALUOP_W'(alu_fn);
                bus.rs2_imm_s = is_itype;
            end
            S_WB: begin
                bus.ALU_OP    = ALUOP_W'(alu_fn);
                bus.rs2_imm_s = is_itype;
                bus.Reg_Write = 1'b1;
                bus.w_data_s  = 2'b00;
            end
            S_MA: begin
                bus.rs2_imm_s = 1'b1;
                bus.Mem_Write = (opc_q == OP_STORE);
            end
            S_LD: begin
                bus.rs2_imm_s = 1'b1;
                bus.Reg_Write = 1'b1;
                bus.w_data_s  = 2'b01;
            end
            S_LUI: begin
                bus.Reg_Write = 1'b1;
                bus.w_data_s  = 2'b10;
            end
            S_BR: begin
                bus.ALU_OP    = ALUOP_W'(ALU_SUB);
                bus.PC_Write  = bus.ZF;
                bus.PC_s      = 2'b01;
            end
            S_JAL: begin
                bus.Reg_Write = 1'b1;
                bus.w_data_s  = 2'b11;
                bus.PC_Write  = 1'b1;
                bus.PC_s      = 2'b01;
            end
            default: ;
        endcase
        if (!rst_n) begin
            bus.Reg_Write = 1'b0;
            bus.Mem_Write = 1'b0;
        end
    end

    assign bus.rs1     = REG_AW'(rs1_q);
    assign bus.rs2     = REG_AW'(rs2_q);
    assign bus.rd      = REG_AW'(rd_q);
    assign bus.imm32   = imm32_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction timeline model plus literal spot checks.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();
    mc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_LUI = 4, K_BEQ = 5, K_JAL = 6, K_ILL = 7;

    typedef struct packed {
        logic        ir, pc, pc0, reg_w, mem_w, ill, bimm;
        logic [1:0]  pcs, wds;
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        c_en, c_rm, c_pcs, c_wds, c_alu, c_imm;
    } exp_t;

    exp_t e;
    logic chk_en;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   memw_cnt = 0;

    // model of latched decode results
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_imm;
    logic        m_imm_ok, m_ill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int classify(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h33: return K_R;
            7'h13: return K_I;
            7'h03: return (f3 == 3'd2) ? K_LW : K_ILL;
            7'h23: return (f3 == 3'd2) ? K_SW : K_ILL;
            7'h37: return K_LUI;
            7'h63: return (f3 == 3'd0) ? K_BEQ : K_ILL;
            7'h6F: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int ncyc(input int kind);
        case (kind)
            K_R, K_I, K_LW: return 4;
            K_ILL:          return 6;
            default:        return 3;
        endcase
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] s;
        s = v << (32 - bits);
        return $signed(s) >>> (32 - bits);
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins, input int kind);
        case (kind)
            K_I, K_LW: return sext({20'b0, ins[31:20]}, 12);
            K_SW:      return sext({20'b0, ins[31:25], ins[11:7]}, 12);
            K_BEQ:     return sext({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
            K_LUI:     return ins & 32'hFFFF_F000;
            K_JAL:     return sext({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [31:0] ins, input int kind);
        logic [3:0] tab [8];
        logic [3:0] r;
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        r = tab[ins[14:12]];
        if (ins[14:12] == 3'd0 && kind == K_R && ins[30]) r = 4'd1;
        if (ins[14:12] == 3'd5 && ins[30]) r = 4'd7;
        return r;
    endfunction

    task automatic model_reset();
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_imm = '0; m_imm_ok = 1'b1; m_ill = 1'b0;
    endtask

    // Expected outputs for cycle k of an instruction (k=0 is the fetch cycle)
    task automatic set_exp(input logic [31:0] ins, input int k, input logic zf, input bit abort);
        exp_t x;
        int   kind;
        kind = classify(ins);
        x = '0;
        x.pcs = 2'b00;
        if (abort) begin
            x.c_rm = 1'b1;
        end else begin
            x.c_en  = 1'b1;
            x.ill   = m_ill;
            x.rs1   = m_rs1; x.rs2 = m_rs2; x.rd = m_rd;
            x.imm   = m_imm;
            x.c_imm = m_imm_ok;
            if (k == 0) begin
                x.ir = 1'b1; x.pc = 1'b1; x.pc0 = 1'b1; x.pcs = 2'b00; x.c_pcs = 1'b1;
            end else if (k >= 2) begin
                case (kind)
                    K_R, K_I: begin
                        x.c_alu = 1'b1; x.alu = alu_of(ins, kind); x.bimm = (kind == K_I);
                        if (k == 3) begin x.reg_w = 1'b1; x.wds = 2'd0; x.c_wds = 1'b1; end
                    end
                    K_LW: begin
                        x.c_alu = 1'b1; x.alu = 4'd0; x.bimm = 1'b1;
                        if (k == 3) begin x.reg_w = 1'b1; x.wds = 2'd1; x.c_wds = 1'b1; end
                    end
                    K_SW: begin
                        x.c_alu = 1'b1; x.alu = 4'd0; x.bimm = 1'b1; x.mem_w = 1'b1;
                    end
                    K_LUI: begin
                        x.reg_w = 1'b1; x.wds = 2'd2; x.c_wds = 1'b1;
                    end
                    K_BEQ: begin
                        x.c_alu = 1'b1; x.alu = 4'd1; x.bimm = 1'b0;
                        x.pc = zf;
                        if (zf) begin x.pcs = 2'b01; x.c_pcs = 1'b1; end
                    end
                    K_JAL: begin
                        x.reg_w = 1'b1; x.wds = 2'd3; x.c_wds = 1'b1;
                        x.pc = 1'b1; x.pcs = 2'b01; x.c_pcs = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        e = x;
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (bus.Mem_Write === 1'b1) memw_cnt++;
        if (chk_en) begin
            if (e.c_en || e.c_rm) begin
                check("Reg_Write", 32'(bus.Reg_Write), 32'(e.reg_w));
                check("Mem_Write", 32'(bus.Mem_Write), 32'(e.mem_w));
            end
            if (e.c_en) begin
                check("IR_Write",  32'(bus.IR_Write),  32'(e.ir));
                check("PC_Write",  32'(bus.PC_Write),  32'(e.pc));
                check("PC0_Write", 32'(bus.PC0_Write), 32'(e.pc0));
                check("illegal",   32'(bus.illegal),   32'(e.ill));
                check("rs1", 32'(bus.rs1), 32'(e.rs1));
                check("rs2", 32'(bus.rs2), 32'(e.rs2));
                check("rd",  32'(bus.rd),  32'(e.rd));
            end
            if (e.c_imm && e.c_en) check("imm32", bus.imm32, e.imm);
            if (e.c_pcs) check("PC_s", 32'(bus.PC_s), 32'(e.pcs));
            if (e.c_wds) check("w_data_s", 32'(bus.w_data_s), 32'(e.wds));
            if (e.c_alu) begin
                check("ALU_OP",    32'(bus.ALU_OP),    32'(e.alu));
                check("rs2_imm_s", 32'(bus.rs2_imm_s), 32'(e.bimm));
            end
        end
    end

    // Run one instruction from its fetch cycle; abort_at>=0 pulses reset in that cycle
    task automatic run(input logic [31:0] ins, input logic zf, input int abort_at);
        int kind;
        int n;
        kind = classify(ins);
        n = ncyc(kind);
        $display("instr 0x%08h kind %0d zf %0d abort_at %0d", ins, kind, zf, abort_at);
        for (int k = 0; k < n; k++) begin
            if (k == 1) bus.inst = ins;
            bus.ZF = zf;
            if (k == abort_at) rst_n = 1'b0;
            set_exp(ins, k, zf, k == abort_at);
            chk_en = 1'b1;
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                rst_n = 1'b1;
                model_reset();
                break;
            end
            if (k == 1) begin
                m_rs1 = ins[19:15]; m_rs2 = ins[24:20]; m_rd = ins[11:7];
                if (kind != K_R && kind != K_ILL) begin
                    m_imm = imm_of(ins, kind); m_imm_ok = 1'b1;
                end else if (kind == K_R) begin
                    m_imm_ok = 1'b0;
                end
                if (kind == K_ILL) m_ill = 1'b1;
            end
        end
    endtask

    int m0;

    initial begin
        rst_n  = 1'b0;
        bus.inst = 32'h0;
        bus.ZF   = 1'b0;
        chk_en = 1'b0;
        e = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_IR_Write", 32'(bus.IR_Write), 32'd1);
        check("reset_PC_Write", 32'(bus.PC_Write), 32'd1);
        check("reset_illegal",  32'(bus.illegal),  32'd0);
        check("reset_imm32",    bus.imm32,         32'd0);
        #1;
        // back to posedge+3 alignment is harmless: run() waits on edges

        run(32'h002081B3, 1'b0, -1);                // add x3,x1,x2
        check("add_rd",  32'(bus.rd),  32'd3);
        check("add_rs1", 32'(bus.rs1), 32'd1);
        check("add_rs2", 32'(bus.rs2), 32'd2);
        run(32'h402081B3, 1'b0, -1);                // sub x3,x1,x2
        run(32'h40010093, 1'b0, -1);                // addi x1,x2,1024 (bit30 set)
        run(32'h40315093, 1'b0, -1);                // srai x1,x2,3
        run(32'h0062F233, 1'b0, -1);                // and x4,x5,x6
        run(32'h00802283, 1'b0, -1);                // lw x5,8(x0)
        check("lw_imm32", bus.imm32, 32'd8);
        check("lw_rd",    32'(bus.rd), 32'd5);
        m0 = memw_cnt;
        run(32'h00502623, 1'b0, -1);                // sw x5,12(x0)
        check("sw_imm32", bus.imm32, 32'd12);
        check("sw_memw_pulses", 32'(memw_cnt - m0), 32'd1);
        run(32'hFE50AE23, 1'b0, -1);                // sw x5,-4(x1)
        check("sw_neg_imm32", bus.imm32, 32'hFFFF_FFFC);
        run(32'h00000463, 1'b1, -1);                // beq taken
        check("beq_imm32", bus.imm32, 32'd8);
        run(32'h00000463, 1'b0, -1);                // beq not taken
        run(32'h123450B7, 1'b0, -1);                // lui x1,0x12345
        check("lui_imm32", bus.imm32, 32'h1234_5000);
        check("lui_rd",    32'(bus.rd), 32'd1);
        run(32'h010000EF, 1'b0, -1);                // jal x1,+16
        check("jal_imm32", bus.imm32, 32'd16);
        run(32'h002081B3, 1'b0, 3);                 // add aborted by reset in WB
        check("abort_IR_Write", 32'(bus.IR_Write), 32'd1);
        run(32'hFFFFFFFF, 1'b0, 5);                 // illegal opcode, then reset
        check("ill_cleared", 32'(bus.illegal),  32'd0);
        check("ill_refetch", 32'(bus.IR_Write), 32'd1);
        run(32'h00001283, 1'b0, 4);                 // lh: unsupported load width
        run(32'h002081B3, 1'b0, -1);                // fetch resumes normally
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
